// File: rtl/sw_enc_pkg.sv
// rtl/sw_enc_pkg.sv - shared constants and types for the switch-word encoder
package sw_enc_pkg;

   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_CODED  = 2'b01;
   localparam logic [1:0] MODE_FAULT  = 2'b10;
   localparam logic [1:0] MODE_RAW    = 2'b11;

   localparam logic [3:0] FAULT_CODE_DEFAULT = 4'b1001;
   localparam logic [9:0] IDLE_WORD          = 10'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/sw_code_map.sv
// rtl/sw_code_map.sv - mode-01 value to payload code table
module sw_code_map (
   input  logic [3:0] value,
   output logic [3:0] code,
   output logic       ok
);

   // 5 is the canonical code for 7; 4, 6 and 8..15 have no code at all
   always_comb begin
      code = 4'd0;
      ok   = 1'b1;
      case (value)
         4'd0:    code = 4'd0;
         4'd1:    code = 4'd1;
         4'd2:    code = 4'd2;
         4'd3:    code = 4'd3;
         4'd5:    code = 4'd4;
         4'd7:    code = 4'd5;
         default: ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/sw_word_encoder.sv
// rtl/sw_word_encoder.sv - encodes (mode, value) requests onto the 10-bit switch word
module sw_word_encoder
   import sw_enc_pkg::*;
#(
   parameter int         HOLD_CYCLES = 4,
   parameter int         GAP_CYCLES  = 1,
   parameter logic [3:0] FAULT_CODE  = FAULT_CODE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_mode,
   input  logic [3:0] in_value,
   output logic [9:0] sw_out,
   output logic [3:0] exp_rez,
   output logic       busy,
   output logic       enc_err,
   output logic [7:0] err_cnt
);

   localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [9:0]       word;
   logic [3:0]       rez;
   logic [9:0]       enc_word;
   logic [3:0]       enc_rez;
   logic             enc_bad;
   logic [3:0]       code;
   logic             code_ok;
   logic             accept;

   sw_code_map u_code_map (
      .value (in_value),
      .code  (code),
      .ok    (code_ok)
   );

   // Fault word is the fallback for mode 10 and for unencodable mode-01 values
   always_comb begin
      enc_word = {MODE_FAULT, 8'b0};
      enc_rez  = FAULT_CODE;
      enc_bad  = 1'b0;
      case (in_mode)
         MODE_DIRECT, MODE_RAW: begin
            enc_word = {in_mode, 4'b0, in_value};
            enc_rez  = in_value;
         end
         MODE_CODED: begin
            if (code_ok) begin
               enc_word = {MODE_CODED, code, 4'b0};
               enc_rez  = in_value;
            end else begin
               enc_bad = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      in_ready   = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_next = DRIVE;
               cnt_next   = HOLD_LOAD;
            end
         end
         DRIVE: begin
            if (cnt == '0) begin
               if (GAP_CYCLES == 0) begin
                  state_next = IDLE;
               end else begin
                  state_next = GAP;
                  cnt_next   = GAP_LOAD;
               end
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt == '0) state_next = IDLE;
            else           cnt_next   = cnt - CNT_W'(1);
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         word    <= IDLE_WORD;
         rez     <= 4'd0;
         enc_err <= 1'b0;
         err_cnt <= 8'd0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         enc_err <= 1'b0;
         if (accept) begin
            word    <= enc_word;
            rez     <= enc_rez;
            enc_err <= enc_bad;
            if (enc_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   // Gated by state so an async reset blanks the bus immediately
   assign sw_out  = (state == DRIVE) ? word : IDLE_WORD;
   assign exp_rez = (state == DRIVE) ? rez  : 4'd0;

endmodule

// File: tb/tb_sw_word_encoder.sv
// tb/tb_sw_word_encoder.sv - directed-vector bench for sw_word_encoder
module tb_sw_word_encoder;

   localparam int HOLD = 4;
   localparam int GAP  = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] in_mode = 2'b00;
   logic [3:0] in_value = 4'd0;
   logic [9:0] sw_out;
   logic [3:0] exp_rez;
   logic       busy;
   logic       enc_err;
   logic [7:0] err_cnt;

   int n_vec = 0;
   int n_bad = 0;

   logic [3:0] dec_rez;
   logic [3:0] exp_rez_d;

   sw_word_encoder #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FAULT_CODE(4'b1001)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_mode  (in_mode),
      .in_value (in_value),
      .sw_out   (sw_out),
      .exp_rez  (exp_rez),
      .busy     (busy),
      .enc_err  (enc_err),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   // Board decoder model: registers its rez one cycle after sw_out
   function automatic logic [3:0] decode(input logic [9:0] w);
      logic [3:0] c;
      c = w[7:4];
      case (w[9:8])
         2'b00, 2'b11: return w[3:0];
         2'b10:        return 4'd9;
         default: begin
            if (c <= 4'd3)      return c;
            else if (c == 4'd4) return 4'd5;
            else if (c == 4'd5) return 4'd7;
            else                return 4'd0;
         end
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_rez   <= 4'd0;
         exp_rez_d <= 4'd0;
      end else begin
         dec_rez   <= decode(sw_out);
         exp_rez_d <= exp_rez;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      check("ready_wait", in_ready, 1);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge back in IDLE
   task automatic send_word(input string tag, input logic [1:0] m, input logic [3:0] v,
                            input logic [9:0] esw, input logic [3:0] erez,
                            input logic eerr, input logic [7:0] ecnt);
      wait_ready();
      in_valid = 1'b1;
      in_mode  = m;
      in_value = v;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < HOLD; i++) begin
         check({tag, "_sw"}, sw_out, esw);
         check({tag, "_rez"}, exp_rez, erez);
         check({tag, "_busy"}, busy, 1);
         check({tag, "_rdy"}, in_ready, 0);
         check({tag, "_err"}, enc_err, (i == 0) ? eerr : 1'b0);
         @(negedge clk);
      end
      for (int i = 0; i < GAP; i++) begin
         check({tag, "_gap_sw"}, sw_out, 0);
         check({tag, "_gap_rez"}, exp_rez, 0);
         check({tag, "_gap_rdy"}, in_ready, 0);
         @(negedge clk);
      end
      check({tag, "_idle_rdy"}, in_ready, 1);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_cnt"}, err_cnt, ecnt);
   endtask

   initial begin
      int acc_idx[$];
      int k;

      @(negedge clk);
      @(negedge clk);
      check("rst_sw", sw_out, 0);
      check("rst_rez", exp_rez, 0);
      check("rst_rdy", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_err", enc_err, 0);
      check("rst_cnt", err_cnt, 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset mid-DRIVE after an error has been counted
      in_valid = 1'b1; in_mode = 2'b01; in_value = 4'd4;
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst_sw", sw_out, 10'h200);
      check("pre_rst_err", enc_err, 1);
      check("pre_rst_cnt", err_cnt, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_sw", sw_out, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rdy", in_ready, 1);
      check("mid_rst_cnt", err_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      send_word("direct_a", 2'b00, 4'hA, 10'h00A, 4'hA, 1'b0, 8'd0);
      send_word("coded_7", 2'b01, 4'd7, 10'h150, 4'd7, 1'b0, 8'd0);
      send_word("coded_5", 2'b01, 4'd5, 10'h140, 4'd5, 1'b0, 8'd0);
      send_word("coded_2", 2'b01, 4'd2, 10'h120, 4'd2, 1'b0, 8'd0);
      send_word("coded_6", 2'b01, 4'd6, 10'h200, 4'd9, 1'b1, 8'd1);
      send_word("raw_f", 2'b11, 4'hF, 10'h30F, 4'hF, 1'b0, 8'd1);
      send_word("fault_3", 2'b10, 4'h3, 10'h200, 4'd9, 1'b0, 8'd1);

      for (int j = 1; j <= 260; j++) begin
         send_word("sat", 2'b01, 4'(8 + (j % 8)), 10'h200, 4'd9, 1'b1,
                   (j + 1 > 255) ? 8'hFF : 8'(j + 1));
      end
      check("sat_final", err_cnt, 8'hFF);

      // in_valid held high: count accepts and compare the decoder model each cycle
      k = 0;
      for (int i = 0; i < 3 * (HOLD + GAP + 1); i++) begin
         in_valid = 1'b1;
         in_mode  = 2'(i);
         in_value = 4'(i % 4 + 1);
         if (in_ready) acc_idx.push_back(i);
         @(negedge clk);
         if (i > 0) begin
            check("dec_vs_exp", dec_rez, exp_rez_d);
            k++;
         end
      end
      in_valid = 1'b0;
      check("stream_accepts", acc_idx.size(), 3);
      if (acc_idx.size() == 3) begin
         check("stream_gap0", acc_idx[1] - acc_idx[0], HOLD + GAP + 1);
         check("stream_gap1", acc_idx[2] - acc_idx[1], HOLD + GAP + 1);
      end
      check("dec_cycles", k, 3 * (HOLD + GAP + 1) - 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
